sum_acum_pipe: RTL
==================

Name: sum_acum_pipe

Overview:
Downstream consumer of the 2-stage 4-bit pipelined adder. It takes the registered adder result and the issue-side valid, delays that valid to line up with the result, and accumulates aligned sums into frames of FRAME_LEN samples. Completed frames, or partial frames on flush, are queued in a 2-entry output buffer and drained through a valid/ready handshake. The block cannot back-pressure the adder, so overflow of the buffer drops frames and flags the loss.

Parameters:
FRAME_LEN, 4, samples per frame (>=2).
ACC_W, 6, accumulator width (>=SUM_W); the result saturates at 2^ACC_W-1.
LEN_W, 3, width of the frame length field; must hold FRAME_LEN.

Ports:
clk  in  1  single clock, rising edge.
reset_L  in  1  asynchronous, active-low reset.
sum_in  in  4  adder result (the adder's registered output).
valid_in  in  1  high in the cycle operands are presented to the adder.
flush  in  1  sync pulse: emit the partial frame.
clear  in  1  sync: discard all state.
out_ready  in  1  sink accepts the head entry.
out_valid  out  1  head entry valid.
acc_out  out  ACC_W  frame sum.
len_out  out  LEN_W  samples in the frame.
ovf_out  out  1  frame saturated.
lost  out  1  sticky: a frame was dropped.
busy  out  1  partial frame in progress (state ACUM).

Behaviour:
- Reset (async, reset_L=0): all outputs 0, accumulator 0, count 0, buffer empty, valid delay line 0, state IDLE.
- Alignment: valid_in high in cycle k makes valid_al high in cycle k+PIPE_LAT (2). sum_in is sampled only at the end of a cycle with valid_al=1.
- Accumulate: acc_next = acc + zero-extended sum_in. If the true sum exceeds 2^ACC_W-1, acc_next = 2^ACC_W-1 and the frame ovf flag sets. The flag stays set until the frame is emitted.
- FSM:
  - IDLE: count=0. An aligned sample moves to ACUM with count=1.
  - ACUM: each aligned sample does count+1.
  - Frame completes when an aligned sample makes count=FRAME_LEN, or when flush=1 in ACUM.
  - On completion, push {acc_next, count_next, ovf}, clear acc, count and ovf, and go to IDLE.
  - flush in IDLE does nothing; no empty frames are emitted.
  - flush together with an aligned sample: the sample is included, then the frame is emitted.
- Latency: the frame completes at the end of cycle t; out_valid=1 from cycle t+1 if the buffer was empty.
- Buffer: 2-entry FIFO, head registered onto acc_out, len_out, ovf_out.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle while full: both succeed.
  - Push while full with no pop: the frame is dropped, lost is set, and the buffer is unchanged.
- Output stability: while out_valid=1 and out_ready=0, acc_out, len_out and ovf_out are held stable.
- Output when empty: out_valid=0 and data fields read 0.
- clear: priority over everything. Empties the buffer, zeroes acc, count, ovf, lost and the delay line, and sets state IDLE in the next cycle. In-flight samples already in the adder are ignored because the delay line is zeroed.
- reset_L asserted mid-frame or mid-handshake: immediate return to reset values; the partial frame and buffered frames are lost.
- lost clears only on clear or reset.

Decomposition:
- Package sum_pipe_pkg:
  - SUM_W=4, PIPE_LAT=2.
  - State enum {ST_IDLE, ST_ACUM}.
  - Frame record type {acc, len, ovf} parameterised by ACC_W/LEN_W.
- Sub-module sum_fifo2: generic 2-entry registered FIFO carrying the frame record.
  - Ports: push, push_data, full, pop, head, empty.
  - Async active-low reset, sync clear.
- Delay line and FSM stay in the top module.

Test Plan:
- Basic frame: valid_in cycles 0-3; sum_in 3,5,7,1 in cycles 2-5. Expect out_valid=1 in cycle 6 with acc_out=16, len_out=4, ovf_out=0; busy=1 in cycles 3-5.
- Saturation (ACC_W=5): four samples of 15. Expect acc_out=31, ovf_out=1, len_out=4. The next frame of four 1s gives acc_out=4, ovf_out=0.
- Flush: samples 2,2 then flush in the same cycle as a third aligned sample of 9. Expect acc_out=13, len_out=3. A flush later in IDLE produces no out_valid.
- Back-pressure and drop: out_ready=0, three frames complete. Expect the first two held in order with stable outputs, the third dropped and lost=1. out_ready=1 then drains the two frames in order, and lost stays 1.
- Full simultaneous push/pop: buffer full, out_ready=1 in the cycle a frame completes. Expect no drop, lost=0, and three frames delivered in order.
- clear and reset mid-frame:
  - Two aligned samples, then clear. Expect out_valid=0, busy=0, the next frame counting from 1, and a valid_in issued in the clear cycle ignored.
  - Repeat with reset_L pulsed low mid-cycle. Expect outputs at 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/sum_pipe_pkg.sv
// Shared constants and types for the pipelined-adder frame accumulator.
// The frame record itself is declared in the top, where ACC_W/LEN_W are known.
package sum_pipe_pkg;

  localparam int SUM_W    = 4;
  localparam int PIPE_LAT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACUM = 1'b1
  } state_e;

endpackage

// File: rtl/sum_fifo2.sv
// Two-entry registered FIFO. Entry 0 is the head and drives the output directly.
// Unused entries are kept at zero, so the head reads 0 when the FIFO is empty.
module sum_fifo2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [1:0]   slot;
  logic         pop_ok, push_ok;

  // A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    pop_ok  = pop && (cnt_q != 2'd0);
    push_ok = push && ((cnt_q != 2'd2) || pop_ok);
    slot    = cnt_q - {1'b0, pop_ok};
    if (clear) begin
      ent0_d = '0;
      ent1_d = '0;
      cnt_d  = 2'd0;
    end else begin
      if (pop_ok) begin
        ent0_d = ent1_q;
        ent1_d = '0;
      end
      if (push_ok) begin
        if (slot == 2'd0) ent0_d = push_data;
        else              ent1_d = push_data;
      end
      cnt_d = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = ent0_q;

endmodule

// File: rtl/sum_acum_pipe.sv
// Accumulates aligned adder results into frames of FRAME_LEN samples and queues
// finished frames for a valid/ready sink; frames that find the queue full are dropped.
module sum_acum_pipe
  import sum_pipe_pkg::*;
#(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 6,
  parameter int LEN_W     = 3
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             valid_in,
  input  logic             flush,
  input  logic             clear,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [LEN_W-1:0] len_out,
  output logic             ovf_out,
  output logic             lost,
  output logic             busy,
  output state_e           state_dbg
);

  // Handshake: a frame transfers on every rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low the head fields do not change.

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] len;
    logic             ovf;
  } frame_t;

  localparam int               FW       = $bits(frame_t);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(FRAME_LEN);

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  lost_q, lost_d;
  logic [PIPE_LAT-1:0]   vdly_q, vdly_d;

  logic                  valid_al;
  logic [ACC_W:0]        sum_wide;
  logic [ACC_W-1:0]      acc_nx;
  logic [LEN_W-1:0]      cnt_nx;
  logic                  ovf_nx;
  logic                  done;
  logic                  push, pop;
  frame_t                push_f, head_f;
  logic                  fifo_full, fifo_empty;

  // valid_in tracks operands entering the adder; the result shows up PIPE_LAT cycles later.
  assign valid_al = vdly_q[PIPE_LAT-1];
  assign vdly_d   = clear ? '0 : {vdly_q[PIPE_LAT-2:0], valid_in};

  always_comb begin
    sum_wide = {1'b0, acc_q} + {{(ACC_W+1-SUM_W){1'b0}}, sum_in};
    acc_nx   = acc_q;
    cnt_nx   = cnt_q;
    ovf_nx   = ovf_q;
    if (valid_al) begin
      acc_nx = sum_wide[ACC_W] ? ACC_MAX : sum_wide[ACC_W-1:0];
      ovf_nx = ovf_q | sum_wide[ACC_W];
      cnt_nx = cnt_q + LEN_ONE;
    end
    // A frame with at least one sample closes on the last sample or on flush.
    done = (cnt_nx != '0) && (flush || (cnt_nx == LEN_FULL));
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    push       = 1'b0;
    push_f.acc = acc_nx;
    push_f.len = cnt_nx;
    push_f.ovf = ovf_nx;
    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_al && !done) begin
            state_d = ST_ACUM;
            acc_d   = acc_nx;
            cnt_d   = cnt_nx;
            ovf_d   = ovf_nx;
          end
        end
        ST_ACUM: begin
          if (!done) begin
            acc_d = acc_nx;
            cnt_d = cnt_nx;
            ovf_d = ovf_nx;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (done) begin
        push    = 1'b1;
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    end
  end

  assign pop    = out_valid && out_ready;
  assign lost_d = clear ? 1'b0 : (lost_q | (push && fifo_full && !pop));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
      vdly_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      lost_q  <= lost_d;
      vdly_q  <= vdly_d;
    end
  end

  sum_fifo2 #(
    .W(FW)
  ) u_fifo (
    .clk       (clk),
    .reset_L   (reset_L),
    .clear     (clear),
    .push      (push),
    .push_data (push_f),
    .full      (fifo_full),
    .pop       (pop),
    .head      (head_f),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign acc_out   = head_f.acc;
  assign len_out   = head_f.len;
  assign ovf_out   = head_f.ovf;
  assign lost      = lost_q;
  assign busy      = (state_q == ST_ACUM);
  assign state_dbg = state_q;

endmodule
